// File: rtl/life_step_engine.sv
// 16x16 Game of Life stepper: one cell per cycle from a snapshot, committed 258 edges after start.
// Optional LIFE_TORUS_EN: board edges wrap in both axes; otherwise off-board neighbours are dead.
module life_step_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [255:0] seed_i,
  input  logic         start,
  output logic [255:0] board_o,
  output logic [15:0]  generation_cnt_o,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]   state;
  logic [255:0] snap;
  logic [255:0] next_board;
  logic [7:0]   idx;
  logic [3:0]   row;
  logic [3:0]   col;
  logic [3:0]   nbr_cnt;
  logic         new_cell;

  assign row = idx[7:4];
  assign col = idx[3:0];

  // Signed coordinates so the -1 / +16 neighbours of edge cells can be recognised.
  function automatic logic cell_at(input logic [255:0] b, input int r, input int c);
`ifdef LIFE_TORUS_EN
    return b[{r[3:0], c[3:0]}];
`else
    if (r < 0 || r > 15 || c < 0 || c > 15) return 1'b0;
    return b[{r[3:0], c[3:0]}];
`endif
  endfunction

  always_comb begin
    nbr_cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0))
          nbr_cnt = nbr_cnt + {3'b000, cell_at(snap, int'(row) + dr, int'(col) + dc)};
      end
    end
  end

  assign new_cell = snap[idx] ? (nbr_cnt == 4'd2 || nbr_cnt == 4'd3) : (nbr_cnt == 4'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      board_o          <= '0;
      generation_cnt_o <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      snap             <= '0;
      next_board       <= '0;
      idx              <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            board_o          <= seed_i;
            generation_cnt_o <= '0;
          end else if (start) begin
            snap  <= board_o;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          next_board[idx] <= new_cell;
          idx             <= idx + 8'd1;
          if (idx == 8'd255) state <= COMMIT;
        end
        COMMIT: begin
          board_o          <= next_board;
          generation_cnt_o <= generation_cnt_o + 16'd1;
          done             <= 1'b1;
          busy             <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
